pipe_done_sync_stage: RTL and testbench
=======================================

// Module: pipe_done_sync_stage
// PURPOSE
//  Generic parametrised pipeline stage register for the CPU pipeline (MEM/WB and later stages).
//  Advances only when every one of NUM_LANES asynchronous-completion sources has reported done.
//  Each lane carries a data word valid only in its done cycle. Early finishers are latched per lane,
//  so no data is lost while other lanes (e.g. IF fetch, DMEM read) are still busy.
//  Adds flush/bubble insertion: a flushed stage presents a NOP (all-zero) to the next stage.
// PARAMETERS
//  CTRL_W     32  width of control payload (op/rd/func3/aluOut packed), held stable by upstream while stalled
//  NUM_LANES  2   number of done/data lanes (1..8)
//  LANE_W     32  width of each lane data word
//  CNT_W      16  width of stall counter (PIPE_STALL_CNT_EN only)
// PORTS
//  clk          in   1                  clock, rising edge
//  rst          in   1                  reset, asynchronous, active-high
//  done_i       in   NUM_LANES          per-lane completion pulse; lane_data_i[l] valid in same cycle
//  lane_data_i  in   NUM_LANES*LANE_W   lane l at bits [l*LANE_W +: LANE_W]
//  ctrl_i       in   CTRL_W             control payload from previous stage
//  flush_i      in   1                  kill in-flight entry, insert bubble
//  ctrl_o       out  CTRL_W             registered control payload
//  lane_data_o  out  NUM_LANES*LANE_W   registered lane data
//  valid_o      out  1                  registered: ctrl_o/lane_data_o hold a live instruction
//  advance_o    out  1                  combinational: stage updates at next clk edge
//  lane_held_o  out  NUM_LANES          registered per-lane "completed, waiting" flags
//  stall_cnt_o  out  CNT_W              saturating stall counter (PIPE_STALL_CNT_EN only)
// BEHAVIOUR
//  - Reset (async): ctrl_o=0, lane_data_o=0, valid_o=0, held=0, buffers=0, stall_cnt_o=0.
//  - ready[l] = done_i[l] | held[l]; advance_o = (&ready) & ~flush_i.
//  - Lane select: sel[l] = held[l] ? buf[l] : lane_data_i[l] (buffered data has priority).
//  - Advance edge: ctrl_o<=ctrl_i, lane_data_o<=sel, valid_o<=1, held<=0, buf<=0. Latency 1 cycle.
//  - No advance, no flush: outputs hold. For each lane with done_i[l] & ~held[l]:
//    buf[l]<=lane_data_i[l], held[l]<=1.
//  - done_i[l] while held[l]=1 and no advance: ignored; buf[l] keeps first value (first-done wins).
//  - All lanes done in same cycle: advance with live data, nothing buffered.
//  - NUM_LANES=1: degenerates to plain register gated by done_i[0].
//  - flush_i=1 (priority over advance and capture): next edge ctrl_o<=0, lane_data_o<=0,
//    valid_o<=0, held<=0, buf<=0; any done_i in that cycle is discarded.
//  - Reset mid-stall clears held flags; outstanding lane completions are lost by design.
//  - Stage never advances with a lane missing; no timeout.
// CONFIGURATION
//  PIPE_STALL_CNT_EN defined: stall_cnt_o increments each cycle with advance_o=0 and flush_i=0,
//   saturates at 2^CNT_W-1, cleared only by rst.
//  PIPE_STALL_CNT_EN undefined: counter not built; stall_cnt_o tied to 0.
// TESTING
//  1. Reset -> all outputs 0; done_i=2'b11, data {B,A}=0x22/0x11, ctrl 0x5 -> next cycle ctrl_o=0x5, data {0x22,0x11}, valid_o=1.
//  2. done_i=2'b10 data1=0xDEAD cycle0, done_i=2'b01 data0=0xBEEF cycle3 (lane1 input now 0x0) -> advance at cycle3, lane_data_o={0xDEAD,0xBEEF}, lane_held_o=2'b10 during cycles1-3.
//  3. Lane0 done twice (0x1 then 0x2) before lane1 -> output lane0=0x1 (first-done wins).
//  4. Lane0 held, flush_i=1 same cycle as lane1 done -> valid_o=0, outputs 0, held=0; subsequent full done pair advances normally.
//  5. Async rst asserted mid-stall with held=2'b01 -> held and outputs 0 immediately, no advance on release until fresh dones.
//  6. PIPE_STALL_CNT_EN, CNT_W=4: 20 stall cycles -> stall_cnt_o=15 (saturated); without macro stall_cnt_o=0.

Source files
------------

// File: rtl/pipe_done_sync_stage_if.sv
// rtl/pipe_done_sync_stage_if.sv - bus bundle between a pipeline stage and its neighbours
interface pipe_done_sync_stage_if #(
  parameter int CTRL_W    = 32,
  parameter int NUM_LANES = 2,
  parameter int LANE_W    = 32,
  parameter int CNT_W     = 16
);
  logic [NUM_LANES-1:0]        done_i;
  logic [NUM_LANES*LANE_W-1:0] lane_data_i;
  logic [CTRL_W-1:0]           ctrl_i;
  logic                        flush_i;
  logic [CTRL_W-1:0]           ctrl_o;
  logic [NUM_LANES*LANE_W-1:0] lane_data_o;
  logic                        valid_o;
  logic                        advance_o;
  logic [NUM_LANES-1:0]        lane_held_o;
  logic [CNT_W-1:0]            stall_cnt_o;

  modport master (
    output done_i, lane_data_i, ctrl_i, flush_i,
    input  ctrl_o, lane_data_o, valid_o, advance_o, lane_held_o, stall_cnt_o
  );

  modport slave (
    input  done_i, lane_data_i, ctrl_i, flush_i,
    output ctrl_o, lane_data_o, valid_o, advance_o, lane_held_o, stall_cnt_o
  );
endinterface

// File: rtl/pipe_done_sync_stage.sv
// rtl/pipe_done_sync_stage.sv - pipeline stage register gated by per-lane done, optional stall counter (PIPE_STALL_CNT_EN)
module pipe_done_sync_stage #(
  parameter int CTRL_W    = 32,
  parameter int NUM_LANES = 2,
  parameter int LANE_W    = 32,
  parameter int CNT_W     = 16
) (
  input logic                    clk,
  input logic                    rst,
  pipe_done_sync_stage_if.slave  bus
);

  localparam int DW = NUM_LANES * LANE_W;

  logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
  logic [DW-1:0]        data_q, data_d;
  logic                 valid_q, valid_d;
  logic [NUM_LANES-1:0] held_q, held_d;
  logic [DW-1:0]        buf_q, buf_d;
  logic [DW-1:0]        sel;
  logic [NUM_LANES-1:0] ready;
  logic                 advance;
  logic [CNT_W-1:0]     stall_cnt;

  // A lane is ready if it completes now or completed earlier; buffered data beats live input.
  always_comb begin
    sel   = '0;
    ready = bus.done_i | held_q;
    for (int l = 0; l < NUM_LANES; l++) begin
      sel[l*LANE_W +: LANE_W] = held_q[l] ? buf_q[l*LANE_W +: LANE_W]
                                          : bus.lane_data_i[l*LANE_W +: LANE_W];
    end
    advance = (&ready) & ~bus.flush_i;
  end

  // Next state: flush clears everything, advance loads the stage, otherwise latch early finishers.
  always_comb begin
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    valid_d = valid_q;
    held_d  = held_q;
    buf_d   = buf_q;
    if (bus.flush_i) begin
      ctrl_d  = '0;
      data_d  = '0;
      valid_d = 1'b0;
      held_d  = '0;
      buf_d   = '0;
    end else if (advance) begin
      ctrl_d  = bus.ctrl_i;
      data_d  = sel;
      valid_d = 1'b1;
      held_d  = '0;
      buf_d   = '0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (bus.done_i[l] && !held_q[l]) begin
          buf_d[l*LANE_W +: LANE_W] = bus.lane_data_i[l*LANE_W +: LANE_W];
          held_d[l]                 = 1'b1;
        end
      end
    end
  end

  // Stage state register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= '0;
      buf_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      buf_q   <= buf_d;
    end
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles the stage sat waiting; only reset clears it.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!advance && !bus.flush_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

  assign bus.ctrl_o      = ctrl_q;
  assign bus.lane_data_o = data_q;
  assign bus.valid_o     = valid_q;
  assign bus.advance_o   = advance;
  assign bus.lane_held_o = held_q;
  assign bus.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_done_sync_stage.sv
// tb/tb_pipe_done_sync_stage.sv - scoreboard bench for pipe_done_sync_stage
module tb_pipe_done_sync_stage;

  localparam int CTRL_W    = 32;
  localparam int NUM_LANES = 2;
  localparam int LANE_W    = 32;
  localparam int CNT_W     = 4;

`ifdef PIPE_STALL_CNT_EN
  localparam int EXP_CNT3  = 3;
  localparam int EXP_CNT20 = 15;
`else
  localparam int EXP_CNT3  = 0;
  localparam int EXP_CNT20 = 0;
`endif

  typedef struct {
    logic [31:0] ctrl;
    logic [63:0] data;
    logic        valid;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  exp_t sb[$];

  pipe_done_sync_stage_if #(
    .CTRL_W(CTRL_W), .NUM_LANES(NUM_LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)
  ) bus ();

  pipe_done_sync_stage #(
    .CTRL_W(CTRL_W), .NUM_LANES(NUM_LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] done, input logic [31:0] d1, input logic [31:0] d0,
                       input logic [31:0] ctrl, input logic flush);
    bus.done_i      = done;
    bus.lane_data_i = {d1, d0};
    bus.ctrl_i      = ctrl;
    bus.flush_i     = flush;
  endtask

  task automatic idle();
    drive(2'b00, 32'h5555_5555, 32'hAAAA_AAAA, 32'h0000_00FF, 1'b0);
  endtask

  task automatic push(input logic [31:0] ctrl, input logic [63:0] data, input logic valid);
    exp_t e;
    e.ctrl  = ctrl;
    e.data  = data;
    e.valid = valid;
    sb.push_back(e);
  endtask

  // Monitor: whenever the stage updates (advance or flush), compare against the next expected entry.
  initial begin
    logic fire;
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      fire = !rst && (bus.advance_o || bus.flush_i);
      @(posedge clk);
      #1;
      if (fire) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_update: got ctrl 0x%0h data 0x%0h, required no update",
                   bus.ctrl_o, bus.lane_data_o);
        end else begin
          e = sb.pop_front();
          chk("mon_ctrl",  64'(bus.ctrl_o), 64'(e.ctrl));
          chk("mon_data",  bus.lane_data_o, e.data);
          chk("mon_valid", 64'(bus.valid_o), 64'(e.valid));
        end
      end
    end
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_ctrl",  64'(bus.ctrl_o), 64'h0);
    chk("rst_data",  bus.lane_data_o, 64'h0);
    chk("rst_valid", 64'(bus.valid_o), 64'h0);
    chk("rst_held",  64'(bus.lane_held_o), 64'h0);
    chk("rst_cnt",   64'(bus.stall_cnt_o), 64'h0);
    rst = 1'b0;

    // 1: both lanes done together
    drive(2'b11, 32'h22, 32'h11, 32'h5, 1'b0);
    push(32'h5, {32'h22, 32'h11}, 1'b1);
    #1 chk("t1_adv", 64'(bus.advance_o), 64'h1);
    @(negedge clk);
    chk("t1_held", 64'(bus.lane_held_o), 64'h0);

    // 2: lane1 early, lane0 three cycles later
    drive(2'b10, 32'hDEAD, 32'h0, 32'h7, 1'b0);
    #1 chk("t2_adv0", 64'(bus.advance_o), 64'h0);
    @(negedge clk);
    chk("t2_held1", 64'(bus.lane_held_o), 64'h2);
    drive(2'b00, 32'h5555, 32'hAAAA, 32'h7, 1'b0);
    #1 chk("t2_adv1", 64'(bus.advance_o), 64'h0);
    @(negedge clk);
    chk("t2_held2", 64'(bus.lane_held_o), 64'h2);
    @(negedge clk);
    chk("t2_held3", 64'(bus.lane_held_o), 64'h2);
    drive(2'b01, 32'h0, 32'hBEEF, 32'h7, 1'b0);
    push(32'h7, {32'hDEAD, 32'hBEEF}, 1'b1);
    #1 chk("t2_adv3", 64'(bus.advance_o), 64'h1);
    @(negedge clk);
    chk("t2_held_clr", 64'(bus.lane_held_o), 64'h0);

    // 3: lane0 done twice before lane1, first value wins
    drive(2'b01, 32'h0, 32'h1, 32'h9, 1'b0);
    @(negedge clk);
    chk("t3_held", 64'(bus.lane_held_o), 64'h1);
    drive(2'b01, 32'h0, 32'h2, 32'h9, 1'b0);
    @(negedge clk);
    drive(2'b10, 32'h33, 32'h77, 32'h9, 1'b0);
    push(32'h9, {32'h33, 32'h1}, 1'b1);
    @(negedge clk);
    idle();

    // 4: flush while lane0 held and lane1 completes
    drive(2'b01, 32'h0, 32'hA, 32'hC, 1'b0);
    @(negedge clk);
    drive(2'b10, 32'hB, 32'h0, 32'hC, 1'b1);
    push(32'h0, 64'h0, 1'b0);
    #1 chk("t4_adv_flush", 64'(bus.advance_o), 64'h0);
    @(negedge clk);
    chk("t4_held", 64'(bus.lane_held_o), 64'h0);
    chk("t4_valid", 64'(bus.valid_o), 64'h0);
    drive(2'b11, 32'h44, 32'h55, 32'hD, 1'b0);
    push(32'hD, {32'h44, 32'h55}, 1'b1);
    @(negedge clk);
    idle();

    // 5: async reset mid-stall
    drive(2'b01, 32'h0, 32'h66, 32'hE, 1'b0);
    @(negedge clk);
    idle();
    chk("t5_held_pre", 64'(bus.lane_held_o), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("t5_held_rst",  64'(bus.lane_held_o), 64'h0);
    chk("t5_valid_rst", 64'(bus.valid_o), 64'h0);
    chk("t5_ctrl_rst",  64'(bus.ctrl_o), 64'h0);
    chk("t5_data_rst",  bus.lane_data_o, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_adv_post",   64'(bus.advance_o), 64'h0);
    chk("t5_valid_post", 64'(bus.valid_o), 64'h0);
    chk("t5_held_post",  64'(bus.lane_held_o), 64'h0);

    // 6: stall counter, three then twenty stall cycles since reset release
    repeat (2) @(negedge clk);
    chk("t6_cnt3", 64'(bus.stall_cnt_o), 64'(EXP_CNT3));
    repeat (17) @(negedge clk);
    chk("t6_cnt20", 64'(bus.stall_cnt_o), 64'(EXP_CNT20));

    drive(2'b11, 32'h77, 32'h88, 32'hF, 1'b0);
    push(32'hF, {32'h77, 32'h88}, 1'b1);
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
